// File: rtl/alu_muldiv_sequencer_if.sv
// alu_muldiv_sequencer_if
//   Bundles the request/result handshake and the borrowed-ALU port group of
//   the iterative multiply/divide sequencer.
//   master : pipeline side (drives start/op/a/b) plus the shared ALU (alu_res)
//   slave  : the sequencer itself
//   Signals: start, op, a, b          request
//            busy, done, div_by_zero  status
//            hi, lo                   result pair
//            alu_a, alu_b, alu_sel    operands driven onto the shared ALU
//            alu_res                  combinational ALU result
interface alu_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_res;

  modport master (
    output start, op, a, b, alu_res,
    input  busy, done, div_by_zero, hi, lo, alu_a, alu_b, alu_sel
  );

  modport slave (
    input  start, op, a, b, alu_res,
    output busy, done, div_by_zero, hi, lo, alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer
//   Iterative unsigned MULTU/DIVU controller. Borrows the EX-stage ALU for one
//   add (multiply) or sub (divide) per cycle over WIDTH cycles and returns the
//   HI/LO pair. Divide by zero finishes immediately with hi=a, lo=all ones.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset; discards any in-flight operation
//     bus  slave modport of alu_muldiv_sequencer_if (request, status,
//          result and the ALU operand/result group)
//   CNT_W must satisfy 2**CNT_W > WIDTH.
module alu_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_muldiv_sequencer_if.slave bus
);

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic [WIDTH-1:0] ph_q;   // P_hi (multiply) / R remainder (divide)
  logic [WIDTH-1:0] pl_q;   // P_lo multiplier (multiply) / Q quotient (divide)
  logic [WIDTH-1:0] m_q;    // M multiplicand / D divisor
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [2:0]       alu_sel_q;

  // One iteration of the datapath, using the ALU result for this cycle.
  logic             carry;
  logic [WIDTH:0]   shl;      // shifted remainder {R, Q[msb]}
  logic             shl_ge;
  logic [WIDTH-1:0] ph_d, pl_d, nxt_a;

  always_comb begin
    carry  = bus.alu_res < ph_q;           // carry-out of P_hi + M
    shl    = {ph_q, pl_q[WIDTH-1]};
    shl_ge = shl >= {1'b0, m_q};           // includes the shl[WIDTH]=1 case
    ph_d   = ph_q;
    pl_d   = pl_q;
    nxt_a  = '0;
    if (!op_q) begin
      if (pl_q[0]) begin
        ph_d = {carry, bus.alu_res[WIDTH-1:1]};
        pl_d = {bus.alu_res[0], pl_q[WIDTH-1:1]};
      end else begin
        ph_d = {1'b0, ph_q[WIDTH-1:1]};
        pl_d = {ph_q[0], pl_q[WIDTH-1:1]};
      end
      nxt_a = ph_d;
    end else begin
      // When shl[WIDTH]=1 the low-word subtract still wraps to the right value.
      if (shl_ge) begin
        ph_d = bus.alu_res;
        pl_d = {pl_q[WIDTH-2:0], 1'b1};
      end else begin
        ph_d = shl[WIDTH-1:0];
        pl_d = {pl_q[WIDTH-2:0], 1'b0};
      end
      nxt_a = {ph_d[WIDTH-2:0], pl_d[WIDTH-1]};
    end
  end

  // ALU operands are registered one cycle ahead so they are stable for the
  // whole RUN cycle and never depend combinationally on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      ph_q      <= '0;
      pl_q      <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= SEL_ADD;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            m_q   <= bus.b;
            pl_q  <= bus.a;
            ph_q  <= '0;
            cnt_q <= '0;
            if (bus.op && (bus.b == '0)) begin
              state_q <= DONE;
              hi_q    <= bus.a;
              lo_q    <= '1;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q   <= RUN;
              dbz_q     <= 1'b0;
              busy_q    <= 1'b1;
              // First operand: P_hi=0 for multiply, {0, a[msb]} for divide.
              alu_a_q   <= bus.op ? {{(WIDTH-1){1'b0}}, bus.a[WIDTH-1]} : '0;
              alu_b_q   <= bus.b;
              alu_sel_q <= bus.op ? SEL_SUB : SEL_ADD;
            end
          end
        end
        RUN: begin
          ph_q  <= ph_d;
          pl_q  <= pl_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            hi_q      <= ph_d;
            lo_q      <= pl_d;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= SEL_ADD;
          end else begin
            alu_a_q <= nxt_a;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_sel     = alu_sel_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
module tb_alu_muldiv_sequencer;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];

  alu_muldiv_sequencer_if #(.WIDTH(W)) bus();

  alu_muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU model
  always_comb begin
    case (bus.alu_sel)
      3'b000:  bus.alu_res = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_res = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_res = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_res = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_res = {{(W-1){1'b0}}, bus.alu_a < bus.alu_b};
      default: bus.alu_res = '0;
    endcase
  end

  // Drive a request for one cycle and push the reference result.
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    if (!op) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e = '{hi: p[2*W-1:W], lo: p[W-1:0], dbz: 1'b0};
    end else if (b == '0) begin
      e = '{hi: a, lo: '1, dbz: 1'b1};
    end else begin
      e = '{hi: a % b, lo: a / b, dbz: 1'b0};
    end
    q.push_back(e);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Step cycles after acceptance until done (bounded). lat=0 on timeout.
  // Optionally pulses start at cycles p1/p2; on return start may still be 1.
  task automatic wait_done(input logic [2:0] sel, input int p1, input int p2,
                           output int lat, output int busy_n, output int sel_bad);
    lat = 0; busy_n = 0; sel_bad = 0;
    for (int n = 1; n <= 100; n++) begin
      if (bus.busy) begin
        busy_n++;
        if (bus.alu_sel !== sel) sel_bad++;
      end
      if (n == p1 || n == p2) begin
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 5; bus.b = 5;
      end
      if (bus.done) begin lat = n; break; end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%0h exp=0", bus.done); end
    n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL rst_dbz got=%0h exp=0", bus.div_by_zero); end
    n_cmp++; if ({bus.hi, bus.lo} !== '0) begin n_err++; $display("FAIL rst_hilo got=%h_%h exp=0", bus.hi, bus.lo); end
    n_cmp++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin n_err++; $display("FAIL rst_alu got=%h %h %b exp=0", bus.alu_a, bus.alu_b, bus.alu_sel); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full-length operation with result and timing checks.
  task automatic test_op(input string nm, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, bn, sb;
    exp_t e;
    issue(op, a, b);
    wait_done(op ? 3'b001 : 3'b000, 0, 0, lat, bn, sb);
    e = q.pop_front();
    n_cmp++; if (lat !== W + 1) begin n_err++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, W + 1); end
    n_cmp++; if (bn !== W) begin n_err++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, bn, W); end
    n_cmp++; if (sb !== 0) begin n_err++; $display("FAIL %s_alu_sel bad_cycles=%0d exp=0", nm, sb); end
    n_cmp++; if (bus.hi !== e.hi) begin n_err++; $display("FAIL %s_hi got=%h exp=%h", nm, bus.hi, e.hi); end
    n_cmp++; if (bus.lo !== e.lo) begin n_err++; $display("FAIL %s_lo got=%h exp=%h", nm, bus.lo, e.lo); end
    n_cmp++; if (bus.div_by_zero !== e.dbz) begin n_err++; $display("FAIL %s_dbz got=%0h exp=%0h", nm, bus.div_by_zero, e.dbz); end
    @(posedge clk); #1;
    n_cmp++; if ({bus.done, bus.busy, bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin
      n_err++; $display("FAIL %s_idle_after got done=%0h busy=%0h alu=%h %h %b exp=0", nm, bus.done, bus.busy, bus.alu_a, bus.alu_b, bus.alu_sel);
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bn, sb;
    exp_t e;
    issue(1'b1, 32'd1234, 32'd0);
    wait_done(3'b001, 0, 0, lat, bn, sb);
    e = q.pop_front();
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    n_cmp++; if (bn !== 0) begin n_err++; $display("FAIL dbz_busy_cycles got=%0d exp=0", bn); end
    n_cmp++; if ({bus.hi, bus.lo, bus.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      n_err++; $display("FAIL dbz_result got=%h/%h/%0h exp=%h/%h/%0h", bus.hi, bus.lo, bus.div_by_zero, e.hi, e.lo, e.dbz);
    end
    @(posedge clk); #1;
    n_cmp++; if ({bus.hi, bus.div_by_zero} !== {32'd1234, 1'b1}) begin
      n_err++; $display("FAIL dbz_hold got=%h/%0h exp=%h/1", bus.hi, bus.div_by_zero, 32'd1234);
    end
    test_op("mul3x3_after_dbz", 1'b0, 32'd3, 32'd3);
  endtask

  task automatic test_ignored_start();
    int lat, bn, sb, extra;
    exp_t e;
    issue(1'b0, 32'd2, 32'd3);
    wait_done(3'b000, 5, W + 1, lat, bn, sb);
    e = q.pop_front();
    n_cmp++; if (lat !== W + 1) begin n_err++; $display("FAIL ign_latency got=%0d exp=%0d", lat, W + 1); end
    n_cmp++; if (sb !== 0) begin n_err++; $display("FAIL ign_alu_sel bad_cycles=%0d exp=0", sb); end
    n_cmp++; if ({bus.hi, bus.lo} !== {e.hi, e.lo}) begin n_err++; $display("FAIL ign_result got=%h_%h exp=%h_%h", bus.hi, bus.lo, e.hi, e.lo); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done || bus.busy) extra++;
      @(posedge clk); #1;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ign_extra_activity got=%0d exp=0", extra); end
    n_cmp++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin n_err++; $display("FAIL ign_idle_alu got=%h %h %b exp=0", bus.alu_a, bus.alu_b, bus.alu_sel); end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    issue(1'b1, 32'd100, 32'd7);
    for (int n = 1; n < 10; n++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    e = q.pop_back();
    n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_err++; $display("FAIL midrst_status got busy=%0h done=%0h exp=0", bus.busy, bus.done); end
    n_cmp++; if ({bus.hi, bus.lo} !== '0) begin n_err++; $display("FAIL midrst_hilo got=%h_%h exp=0 (discarded %h)", bus.hi, bus.lo, e.lo); end
    rst = 1'b0;
    @(posedge clk); #1;
    test_op("mul_after_rst", 1'b0, 32'd7, 32'd6);
  endtask

  initial begin
    test_reset();
    test_op("mul7x6", 1'b0, 32'd7, 32'd6);
    test_op("mul_ffff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_op("div100_7", 1'b1, 32'd100, 32'd7);
    test_op("div_topbit", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    test_div_by_zero();
    test_ignored_start();
    test_reset_mid_op();
    test_op("mul_rand", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    test_op("div_rand", 1'b1, 32'hDEAD_BEEF, 32'h0000_1235);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
